// File: rtl/z80_io_master.sv
// Z80-style I/O bus master: runs one IN/OUT cycle (T1, T2, TW..., T3) per accepted
// command, paced by the CPU T-state strobe, and reports completion with a one-cycle pulse.
module z80_io_master #(
  parameter int WAIT_STATES = 1
) (
  input  logic        clk28,
  input  logic        rst,
  input  logic        t_en,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  input  logic        wait_n,
  input  logic [7:0]  d_in,
  input  logic        d_in_active,
  output logic        ioreq,
  output logic        rd,
  output logic        wr,
  output logic [15:0] a,
  output logic [7:0]  d_out,
  output logic        d_oe,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_TW,
    S_T3
  } state_t;

  state_t      state_reg, state_next;
  logic        wr_reg, wr_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic        accept;
  logic        capture;
  logic        strobe_next;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = (state_reg == S_IDLE) && cmd_valid;
    wr_next    = accept ? cmd_wr : wr_reg;
    case (state_reg)
      S_IDLE: if (accept) state_next = S_T1;
      S_T1:   if (t_en) state_next = S_T2;
      S_T2: begin
        if (t_en) begin
          state_next = S_TW;
          cnt_next   = 3'(WAIT_STATES);
        end
      end
      S_TW: begin
        // The count reaching zero on this strobe already ends the forced waits,
        // so WAIT_STATES=N gives N TW states and 0 still yields one.
        if (t_en) begin
          if (cnt_reg != 3'd0) cnt_next = cnt_reg - 3'd1;
          if ((cnt_reg <= 3'd1) && wait_n) state_next = S_T3;
        end
      end
      S_T3:   if (t_en) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    capture     = (state_reg == S_TW) && (state_next == S_T3);
    strobe_next = (state_next == S_T2) || (state_next == S_TW);
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      state_reg <= S_IDLE;
      wr_reg    <= 1'b0;
      cnt_reg   <= 3'd0;
      ioreq     <= 1'b0;
      rd        <= 1'b0;
      wr        <= 1'b0;
      d_oe      <= 1'b0;
      a         <= 16'h0000;
      d_out     <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'hFF;
    end else begin
      state_reg <= state_next;
      wr_reg    <= wr_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        a     <= cmd_addr;
        d_out <= cmd_data;
      end
      ioreq     <= strobe_next;
      rd        <= strobe_next && !wr_next;
      wr        <= strobe_next && wr_next;
      d_oe      <= wr_next && (state_next != S_IDLE);
      rsp_valid <= (state_reg == S_T3) && (state_next == S_IDLE);
      if (capture) rsp_data <= wr_reg ? 8'hFF : (d_in_active ? d_in : 8'hFF);
    end
  end

  assign cmd_ready = (state_reg == S_IDLE);
  assign busy      = (state_reg != S_IDLE);

endmodule
